aes_ctr_driver: RTL and testbench

//  Initiator side of the AES core handshake (en/ready/valid) for CTR/GCM mode.

---
 rtl/aes_ctr_driver.sv | 117 +++++++++++
 tb/tb_aes_ctr_driver.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_driver.sv
// CTR/GCM initiator for an AES core: issues IV||ctr32 counter blocks one at a time,
// XORs each returned keystream block with the plaintext stream, and emits ciphertext.
module aes_ctr_driver #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] CTR_INIT = 32'd2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [95:0]        i_iv,
    input  logic [CNT_W-1:0]   i_num_blocks,
    output logic               o_busy,
    output logic               o_done,
    input  logic               i_pt_valid,
    input  logic [127:0]       i_pt_data,
    output logic               o_pt_ready,
    output logic               o_ct_valid,
    output logic [127:0]       o_ct_data,
    input  logic               i_ct_ready,
    output logic               o_aes_en,
    output logic [127:0]       o_aes_block,
    input  logic               i_aes_ready,
    input  logic               i_aes_valid,
    input  logic [127:0]       i_aes_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_KS,
        S_XOR,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [95:0]      iv_q;
    logic [31:0]      ctr_q;
    logic [CNT_W-1:0] rem_q;
    logic [127:0]     ks_q;

    logic pt_fire;
    logic ct_fire;

    assign o_busy      = (state_q != S_IDLE);
    assign o_aes_en    = (state_q == S_ISSUE) && i_aes_ready;
    assign o_pt_ready  = (state_q == S_XOR) && (!o_ct_valid || i_ct_ready);
    assign o_aes_block = {iv_q, ctr_q};

    assign pt_fire = i_pt_valid && o_pt_ready;
    assign ct_fire = o_ct_valid && i_ct_ready;

    // NOTE: every register here, including the 128-bit data holders, is plain flops
    // (not a memory), so clearing them all in the async reset branch is cheap and
    // guarantees nothing from an aborted run can leak into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            iv_q       <= '0;
            ctr_q      <= '0;
            rem_q      <= '0;
            ks_q       <= '0;
            o_ct_valid <= 1'b0;
            o_ct_data  <= '0;
            o_done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below sees
            // the pre-edge values of state_q, rem_q and o_ct_valid.
            o_done <= 1'b0;

            // A fresh ciphertext beat takes priority over draining the current one.
            if (pt_fire) begin
                o_ct_data  <= i_pt_data ^ ks_q;
                o_ct_valid <= 1'b1;
            end else if (ct_fire) begin
                o_ct_data  <= '0;
                o_ct_valid <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        iv_q    <= i_iv;
                        ctr_q   <= CTR_INIT;
                        rem_q   <= i_num_blocks;
                        state_q <= (i_num_blocks == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_aes_ready) state_q <= S_WAIT_KS;
                end
                S_WAIT_KS: begin
                    if (i_aes_valid) begin
                        ks_q    <= i_aes_data;
                        state_q <= S_XOR;
                    end
                end
                S_XOR: begin
                    if (pt_fire) begin
                        ctr_q   <= ctr_q + 32'd1;
                        rem_q   <= rem_q - CNT_W'(1);
                        state_q <= (rem_q == CNT_W'(1)) ? S_FLUSH : S_ISSUE;
                    end
                end
                S_FLUSH: begin
                    if (!o_ct_valid || i_ct_ready) state_q <= S_DONE;
                end
                S_DONE: begin
                    o_done  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ctr_driver.sv
// Scoreboard bench for aes_ctr_driver: a behavioural AES core and plaintext source feed
// the DUT, expected counter blocks and ciphertext are queued up front and popped by a monitor.
module tb_aes_ctr_driver;

    localparam logic [31:0] CTR_INIT = 32'd2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic [95:0]  i_iv = '0;
    logic [15:0]  i_num_blocks = '0;
    logic         o_busy, o_done;
    logic         i_pt_valid = 1'b0;
    logic [127:0] i_pt_data = '0;
    logic         o_pt_ready;
    logic         o_ct_valid;
    logic [127:0] o_ct_data;
    logic         i_ct_ready = 1'b1;
    logic         o_aes_en;
    logic [127:0] o_aes_block;
    logic         i_aes_ready = 1'b1;
    logic         i_aes_valid = 1'b0;
    logic [127:0] i_aes_data = '0;

    // Second instance with a counter start that wraps after the first block.
    logic         start_w = 1'b0;
    logic [95:0]  iv_w = '0;
    logic [15:0]  num_w = '0;
    logic         busy_w, done_w, pt_ready_w, ct_valid_w, aes_en_w;
    logic [127:0] ct_data_w, aes_block_w;
    logic         aes_valid_w = 1'b0;
    logic [127:0] aes_data_w = '0;
    logic [127:0] pt_data_w = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    always #5 clk = ~clk;

    aes_ctr_driver #(.CNT_W(16), .CTR_INIT(CTR_INIT)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_iv(i_iv),
        .i_num_blocks(i_num_blocks), .o_busy(o_busy), .o_done(o_done),
        .i_pt_valid(i_pt_valid), .i_pt_data(i_pt_data), .o_pt_ready(o_pt_ready),
        .o_ct_valid(o_ct_valid), .o_ct_data(o_ct_data), .i_ct_ready(i_ct_ready),
        .o_aes_en(o_aes_en), .o_aes_block(o_aes_block), .i_aes_ready(i_aes_ready),
        .i_aes_valid(i_aes_valid), .i_aes_data(i_aes_data)
    );

    aes_ctr_driver #(.CNT_W(16), .CTR_INIT(32'hFFFF_FFFF)) dut_w (
        .clk(clk), .rst_n(rst_n), .i_start(start_w), .i_iv(iv_w),
        .i_num_blocks(num_w), .o_busy(busy_w), .o_done(done_w),
        .i_pt_valid(1'b1), .i_pt_data(pt_data_w), .o_pt_ready(pt_ready_w),
        .o_ct_valid(ct_valid_w), .o_ct_data(ct_data_w), .i_ct_ready(1'b1),
        .o_aes_en(aes_en_w), .o_aes_block(aes_block_w), .i_aes_ready(1'b1),
        .i_aes_valid(aes_valid_w), .i_aes_data(aes_data_w)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, en_cnt = 0, done_cnt = 0, hs_cyc = 0, done_cyc = 0;
    int lat = 2;
    int ks_mode = 0;
    logic [127:0] exp_blk_q[$];
    logic [127:0] exp_ct_q[$];
    logic [127:0] pt_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Keystream the fake core returns for a given counter block.
    function automatic logic [127:0] ks_fn(input logic [127:0] blk);
        if (ks_mode == 0) return '1;
        return {blk[63:0], blk[127:64]} ^ 128'h5A5A_A5A5_0F0F_F0F0_3C3C_C3C3_9696_6969;
    endfunction

    always @(posedge clk) cyc++;

    // Behavioural AES core: busy for lat cycles after each accepted en.
    initial forever begin
        logic [127:0] blk;
        @(negedge clk);
        if (o_aes_en) begin
            blk = o_aes_block;
            @(posedge clk); #1 i_aes_ready = 1'b0;
            repeat (lat - 1) @(posedge clk);
            #1 i_aes_valid = 1'b1; i_aes_data = ks_fn(blk);
            @(posedge clk); #1 i_aes_valid = 1'b0; i_aes_ready = 1'b1; i_aes_data = '0;
        end
    end

    // Plaintext source: presents the head of pt_q until it is accepted.
    initial forever begin
        logic fire;
        @(negedge clk);
        fire = i_pt_valid && o_pt_ready;
        @(posedge clk); #1;
        if (fire && pt_q.size() > 0) void'(pt_q.pop_front());
        if (pt_q.size() > 0) begin
            i_pt_valid = 1'b1; i_pt_data = pt_q[0];
        end else begin
            i_pt_valid = 1'b0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an en or a ct beat.
    always @(negedge clk) if (rst_n) begin
        if (o_aes_en) begin
            en_cnt++;
            if (exp_blk_q.size() == 0) check("en_extra", 128'(exp_blk_q.size()), 128'd1);
            else check("en_block", o_aes_block, exp_blk_q.pop_front());
        end
        if (o_ct_valid && i_ct_ready) begin
            hs_cyc = cyc;
            if (exp_ct_q.size() == 0) check("ct_extra", 128'(exp_ct_q.size()), 128'd1);
            else check("ct_data", o_ct_data, exp_ct_q.pop_front());
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_not_busy", 128'(o_busy), 128'd0);
        end
    end

    task automatic start_run(input logic [95:0] iv, input int n, input logic [127:0] pts [4]);
        logic [127:0] blk;
        for (int i = 0; i < n; i++) begin
            blk = {iv, CTR_INIT + 32'(i)};
            exp_blk_q.push_back(blk);
            exp_ct_q.push_back(pts[i] ^ ks_fn(blk));
            pt_q.push_back(pts[i]);
        end
        @(posedge clk); #1 i_start = 1'b1; i_iv = iv; i_num_blocks = 16'(n);
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt, input string name);
        int k = 0;
        while (done_cnt == start_cnt && k < 200) begin
            @(negedge clk); k++;
        end
        check(name, 128'(done_cnt - start_cnt), 128'd1);
        check({name, "_sb_empty"}, 128'(exp_ct_q.size() + exp_blk_q.size()), 128'd0);
    endtask

    initial begin
        logic [127:0] pts [4];
        logic [127:0] held;
        int d0, e0, k;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 128'(o_busy), 128'd0);
        check("rst_outs", 128'({o_done, o_pt_ready, o_ct_valid, o_aes_en}), 128'd0);
        check("rst_ct_data", o_ct_data, 128'd0);
        check("rst_aes_block", o_aes_block, 128'd0);
        check("rst_w_busy", 128'(busy_w), 128'd0);
        @(negedge clk); rst_n = 1'b1;

        // 1: single block, all-ones keystream -> CT = ~PT
        ks_mode = 0;
        pts = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '0, '0, '0};
        d0 = done_cnt;
        start_run(96'h0, 1, pts);
        wait_done(d0, "t1_done");
        check("t1_done_after_ct", 128'(done_cyc - hs_cyc), 128'd2);

        // 2: three blocks, counters 2,3,4, one done
        ks_mode = 1;
        pts = '{128'hAAAA_0000_1111_2222_3333_4444_5555_6666,
                128'h0F0F_0F0F_F0F0_F0F0_1234_5678_9ABC_DEF0,
                128'hDEAD_BEEF_CAFE_BABE_0000_FFFF_8001_7FFE, '0};
        d0 = done_cnt; e0 = en_cnt;
        start_run(96'hCAFE_F00D_1234_5678_9ABC_DEF0, 3, pts);
        wait_done(d0, "t2_done");
        repeat (3) @(negedge clk);
        check("t2_en_count", 128'(en_cnt - e0), 128'd3);
        check("t2_one_done", 128'(done_cnt - d0), 128'd1);

        // 3: downstream stalled for 10 cycles
        pts = '{128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0,
                128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, '0, '0};
        #1 i_ct_ready = 1'b0;
        d0 = done_cnt;
        start_run(96'h0000_0001_0000_0002_0000_0003, 2, pts);
        k = 0;
        while (!o_ct_valid && k < 50) begin @(negedge clk); k++; end
        check("t3_ct_valid_seen", 128'(o_ct_valid), 128'd1);
        held = o_ct_data;
        check("t3_held_value", held, exp_ct_q[0]);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_stable_data", o_ct_data, held);
            check("t3_stable_valid_pt_ready", 128'({o_ct_valid, o_pt_ready}), 128'b10);
        end
        check("t3_no_early_done", 128'(done_cnt - d0), 128'd0);
        @(posedge clk); #1 i_ct_ready = 1'b1;
        wait_done(d0, "t3_done");

        // 4: counter wrap on the second instance
        iv_w = 96'h0123_4567_89AB_CDEF_0011_2233;
        @(posedge clk); #1 start_w = 1'b1; num_w = 16'd2;
        @(posedge clk); #1 start_w = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!aes_en_w && k < 20);
        check("t4_en1", 128'(aes_en_w), 128'd1);
        check("t4_block1", aes_block_w, {96'h0123_4567_89AB_CDEF_0011_2233, 32'hFFFF_FFFF});
        @(posedge clk); #1 aes_valid_w = 1'b1; aes_data_w = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
        @(posedge clk); #1 aes_valid_w = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!aes_en_w && k < 20);
        check("t4_en2", 128'(aes_en_w), 128'd1);
        check("t4_block2_wrap", aes_block_w, {96'h0123_4567_89AB_CDEF_0011_2233, 32'h0000_0000});
        check("t4_ct1", ct_data_w, 128'h1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878_8787);
        @(posedge clk); #1 aes_valid_w = 1'b1;
        @(posedge clk); #1 aes_valid_w = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!done_w && k < 20);
        check("t4_done", 128'(done_w), 128'd1);

        // 5: zero blocks -> DONE then done pulse, no en
        d0 = done_cnt; e0 = en_cnt;
        @(posedge clk); #1 i_start = 1'b1; i_num_blocks = 16'd0;
        @(posedge clk); #1 i_start = 1'b0;
        @(negedge clk);
        check("t5_busy_done_c1", 128'({o_busy, o_done}), 128'b10);
        @(negedge clk);
        check("t5_busy_done_c2", 128'({o_busy, o_done}), 128'b01);
        @(negedge clk);
        check("t5_no_en", 128'(en_cnt - e0), 128'd0);
        check("t5_one_done", 128'(done_cnt - d0), 128'd1);

        // 6: reset while waiting for keystream
        lat = 6;
        pts = '{128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA,
                128'h1, 128'h2, '0};
        start_run(96'hFEED_FACE_0BAD_C0DE_1234_4321, 3, pts);
        k = 0;
        while (!o_aes_en && k < 20) begin @(negedge clk); k++; end
        @(negedge clk);
        check("t6_busy_before_rst", 128'(o_busy), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_flags", 128'({o_busy, o_done, o_pt_ready, o_ct_valid, o_aes_en}), 128'd0);
        check("t6_rst_block", o_aes_block, 128'd0);
        check("t6_rst_ct", o_ct_data, 128'd0);
        exp_blk_q.delete(); exp_ct_q.delete(); pt_q.delete();
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("t6_late_ks_ignored", 128'({o_busy, o_ct_valid, o_pt_ready}), 128'd0);
        end
        lat = 2;
        pts = '{128'hC0FF_EE00_C0FF_EE00_C0FF_EE00_C0FF_EE00, '0, '0, '0};
        d0 = done_cnt;
        start_run(96'h0BB0_0BB0_0BB0_0BB0_0BB0_0BB0, 1, pts);
        wait_done(d0, "t6_restart_done");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
